// File: rtl/rv_wb_pkg.sv
// Shared encodings for the miniRV writeback stage: writeback source select and load type.
package rv_wb_pkg;

  typedef enum logic [1:0] {
    WD_SEL_ALU  = 2'd0,
    WD_SEL_LOAD = 2'd1,
    WD_SEL_PC4  = 2'd2,
    WD_SEL_IMM  = 2'd3
  } wd_sel_e;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LH  = 3'd1,
    LD_LW  = 3'd2,
    LD_LBU = 3'd4,
    LD_LHU = 3'd5
  } ld_type_e;

endpackage

// File: rtl/rf_writeback_if.sv
// MEM-to-WB instruction bundle; MEM side drives (master), WB side receives (slave).
interface rf_writeback_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_valid;
  logic            mem_rf_we;
  logic [4:0]      mem_rd;
  logic [1:0]      mem_wd_sel;
  logic [2:0]      mem_ld_type;
  logic [XLEN-1:0] mem_alu_res;
  logic [XLEN-1:0] mem_pc4;
  logic [XLEN-1:0] mem_imm;

  modport master (
    output mem_valid, mem_rf_we, mem_rd, mem_wd_sel, mem_ld_type,
    output mem_alu_res, mem_pc4, mem_imm
  );

  modport slave (
    input mem_valid, mem_rf_we, mem_rd, mem_wd_sel, mem_ld_type,
    input mem_alu_res, mem_pc4, mem_imm
  );
endinterface

// File: rtl/load_ext.sv
// Load data lane selection and sign/zero extension from a 32-bit DRAM read word.
module load_ext
  import rv_wb_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      ld_type,
  output logic [XLEN-1:0] data
);
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_v = rdata[7:0];
      2'd1:    byte_v = rdata[15:8];
      2'd2:    byte_v = rdata[23:16];
      default: byte_v = rdata[31:24];
    endcase
    // Misaligned halfwords fall into lane addr_lo[1]; no trap is raised.
    half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (ld_type)
      LD_LB:   data = {{(XLEN-8){byte_v[7]}}, byte_v};
      LD_LBU:  data = {{(XLEN-8){1'b0}}, byte_v};
      LD_LH:   data = {{(XLEN-16){half_v[15]}}, half_v};
      LD_LHU:  data = {{(XLEN-16){1'b0}}, half_v};
      default: data = rdata;
    endcase
  end
endmodule

// File: rtl/rf_writeback.sv
// MEM/WB pipeline register and register-file write-port driver with WB forwarding and retire count.
module rf_writeback
  import rv_wb_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 flush,
  rf_writeback_if.slave        mem_if,
  input  logic [XLEN-1:0]      dram_rdata,
  output logic                 rf_we,
  output logic [4:0]           rf_wR,
  output logic [XLEN-1:0]      rf_wD,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [XLEN-1:0]      fwd_data,
  output logic [INSTRET_W-1:0] instret
);
  logic            wb_valid;
  logic            wb_rf_we;
  logic [4:0]      wb_rd;
  logic [1:0]      wb_wd_sel;
  logic [2:0]      wb_ld_type;
  logic [XLEN-1:0] wb_alu_res;
  logic [XLEN-1:0] wb_pc4;
  logic [XLEN-1:0] wb_imm;
  logic [XLEN-1:0] load_val;
  logic [XLEN-1:0] wb_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid   <= 1'b0;
      wb_rf_we   <= 1'b0;
      wb_rd      <= '0;
      wb_wd_sel  <= '0;
      wb_ld_type <= '0;
      wb_alu_res <= '0;
      wb_pc4     <= '0;
      wb_imm     <= '0;
    end else if (flush) begin
      wb_valid <= 1'b0;
      wb_rf_we <= 1'b0;
    end else if (!stall) begin
      wb_valid   <= mem_if.mem_valid;
      wb_rf_we   <= mem_if.mem_rf_we;
      wb_rd      <= mem_if.mem_rd;
      wb_wd_sel  <= mem_if.mem_wd_sel;
      wb_ld_type <= mem_if.mem_ld_type;
      wb_alu_res <= mem_if.mem_alu_res;
      wb_pc4     <= mem_if.mem_pc4;
      wb_imm     <= mem_if.mem_imm;
    end
  end

  // An entry retires when the slot is overwritten; a flush also overwrites a stalled slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (wb_valid && (flush || !stall)) begin
      instret <= instret + INSTRET_W'(1);
    end
  end

  load_ext #(.XLEN(XLEN)) u_load_ext (
    .rdata   (dram_rdata),
    .addr_lo (wb_alu_res[1:0]),
    .ld_type (wb_ld_type),
    .data    (load_val)
  );

  always_comb begin
    case (wb_wd_sel)
      WD_SEL_LOAD: wb_val = load_val;
      WD_SEL_PC4:  wb_val = wb_pc4;
      WD_SEL_IMM:  wb_val = wb_imm;
      default:     wb_val = wb_alu_res;
    endcase
    rf_we     = wb_valid & wb_rf_we & (wb_rd != '0);
    rf_wR     = rf_we ? wb_rd : '0;
    rf_wD     = rf_we ? wb_val : '0;
    fwd_valid = rf_we;
    fwd_rd    = rf_wR;
    fwd_data  = rf_wD;
  end
endmodule

// File: tb/tb_rf_writeback.sv
// Randomized and directed bench for rf_writeback against a slot-level behavioural model.
module tb_rf_writeback;
  import rv_wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] dram_rdata;
  logic        rf_we;
  logic [4:0]  rf_wR;
  logic [31:0] rf_wD;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [63:0] instret;

  always #5 clk = ~clk;

  rf_writeback_if #(.XLEN(32)) mif ();

  rf_writeback #(.XLEN(32), .INSTRET_W(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .flush      (flush),
    .mem_if     (mif),
    .dram_rdata (dram_rdata),
    .rf_we      (rf_we),
    .rf_wR      (rf_wR),
    .rf_wD      (rf_wD),
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data),
    .instret    (instret)
  );

  typedef struct {
    logic        v;
    logic        we;
    logic [4:0]  rd;
    logic [1:0]  sel;
    logic [2:0]  ld;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] imm;
  } ins_t;

  ins_t        slot;
  ins_t        nop;
  logic [63:0] m_instret;
  logic [63:0] snap;
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [2:0]  lt[6];
  logic [1:0]  la[6];
  logic [31:0] le[6];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic ins_t mk(input logic v, input logic we, input logic [4:0] rd,
                              input logic [1:0] sel, input logic [2:0] ld,
                              input logic [31:0] alu, input logic [31:0] pc4,
                              input logic [31:0] imm);
    ins_t r;
    r.v = v; r.we = we; r.rd = rd; r.sel = sel; r.ld = ld;
    r.alu = alu; r.pc4 = pc4; r.imm = imm;
    return r;
  endfunction

  function automatic ins_t rnd_ins();
    return mk(1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom), 3'($urandom),
              $urandom, $urandom, $urandom);
  endfunction

  // Reference write data: lane extraction by shifting, extension by masking.
  function automatic logic [31:0] exp_wd(input logic [31:0] word);
    logic [31:0] v;
    case (slot.sel)
      2'd0: return slot.alu;
      2'd2: return slot.pc4;
      2'd3: return slot.imm;
      default: begin
        if (slot.ld == 3'd0 || slot.ld == 3'd4) begin
          v = (word >> (8 * slot.alu[1:0])) & 32'hFF;
          if (slot.ld == 3'd0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
          return v;
        end
        if (slot.ld == 3'd1 || slot.ld == 3'd5) begin
          v = (word >> (16 * slot.alu[1])) & 32'hFFFF;
          if (slot.ld == 3'd1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
          return v;
        end
        return word;
      end
    endcase
  endfunction

  task automatic check_outputs();
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    e_we = slot.v && slot.we && (slot.rd != 5'd0);
    e_rd = e_we ? slot.rd : 5'd0;
    e_wd = e_we ? exp_wd(dram_rdata) : 32'd0;
    chk("rf_we", 64'(rf_we), 64'(e_we));
    chk("rf_wR", 64'(rf_wR), 64'(e_rd));
    chk("rf_wD", 64'(rf_wD), 64'(e_wd));
    chk("fwd_valid", 64'(fwd_valid), 64'(e_we));
    chk("fwd_rd", 64'(fwd_rd), 64'(e_rd));
    chk("fwd_data", 64'(fwd_data), 64'(e_wd));
    chk("instret", instret, m_instret);
  endtask

  task automatic cyc(input ins_t in, input logic st, input logic fl, input logic rs,
                     input logic [31:0] word);
    mif.mem_valid   = in.v;
    mif.mem_rf_we   = in.we;
    mif.mem_rd      = in.rd;
    mif.mem_wd_sel  = in.sel;
    mif.mem_ld_type = in.ld;
    mif.mem_alu_res = in.alu;
    mif.mem_pc4     = in.pc4;
    mif.mem_imm     = in.imm;
    stall = st;
    flush = fl;
    rst_n = rs;
    if (!rs) begin
      slot      = nop;
      m_instret = '0;
    end else begin
      if (slot.v && (fl || !st)) m_instret = m_instret + 64'd1;
      if (fl) begin
        slot.v  = 1'b0;
        slot.we = 1'b0;
      end else if (!st) begin
        slot = in;
      end
    end
    @(posedge clk);
    #1 dram_rdata = word;
    #1 check_outputs();
  endtask

  initial begin
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
    slot = nop;
    m_instret = '0;
    dram_rdata = '0;
    lt = '{3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    la = '{2'd1, 2'd3, 2'd3, 2'd2, 2'd2, 2'd0};
    le = '{32'h0000_007F, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};

    cyc(nop, 0, 0, 0, 0);
    chk("reset_instret", instret, 64'd0);
    chk("reset_we", 64'(rf_we), 64'd0);
    cyc(nop, 0, 0, 1, 0);

    // ALU write then retire
    cyc(mk(1, 1, 5, WD_SEL_ALU, 0, 32'h1234, 0, 0), 0, 0, 1, 32'hDEAD_BEEF);
    chk("alu_we", 64'(rf_we), 64'd1);
    chk("alu_wR", 64'(rf_wR), 64'd5);
    chk("alu_wD", 64'(rf_wD), 64'h1234);
    cyc(nop, 0, 0, 1, 0);
    chk("alu_instret", instret, 64'd1);

    // x0 guard
    cyc(mk(1, 1, 0, WD_SEL_ALU, 0, 32'hFFFF, 0, 0), 0, 0, 1, 0);
    chk("x0_we", 64'(rf_we), 64'd0);
    chk("x0_wR", 64'(rf_wR), 64'd0);
    chk("x0_wD", 64'(rf_wD), 64'd0);
    chk("x0_fwd", 64'(fwd_valid), 64'd0);

    // load extension table
    for (int i = 0; i < 6; i++) begin
      cyc(mk(1, 1, 7, WD_SEL_LOAD, lt[i], {30'h0400, la[i]}, 0, 0), 0, 0, 1, 32'h80FF_7F01);
      chk("load_wD", 64'(rf_wD), 64'(le[i]));
    end

    // JAL held under stall, then flush+stall
    cyc(mk(1, 1, 1, WD_SEL_PC4, 0, 32'h55, 32'h104, 0), 0, 0, 1, 0);
    snap = m_instret;
    for (int i = 0; i < 3; i++) begin
      cyc(rnd_ins(), 1, 0, 1, $urandom);
      chk("stall_wD", 64'(rf_wD), 64'h104);
      chk("stall_instret", instret, snap);
    end
    cyc(rnd_ins(), 1, 1, 1, $urandom);
    chk("flush_we", 64'(rf_we), 64'd0);

    // synchronous reset: nothing changes before the edge
    cyc(mk(1, 1, 9, WD_SEL_ALU, 0, 32'hABCD, 0, 0), 0, 0, 1, 0);
    rst_n = 1'b0;
    #1 chk("rst_pre_we", 64'(rf_we), 64'd1);
    cyc(mk(1, 1, 3, WD_SEL_ALU, 0, 32'h77, 0, 0), 0, 0, 0, 0);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_instret", instret, 64'd0);

    // back-to-back writes
    for (int i = 1; i <= 4; i++) begin
      cyc(mk(1, 1, 5'(i), WD_SEL_IMM, 0, 0, 0, 32'(i * 16)), 0, 0, 1, 0);
      chk("b2b_wR", 64'(rf_wR), 64'(i));
    end
    cyc(nop, 0, 0, 1, 0);
    chk("b2b_instret", instret, 64'd4);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(rnd_ins(), ($urandom_range(3) == 0), ($urandom_range(7) == 0),
          ($urandom_range(39) != 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
